// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_pkg
// Purpose  : Shared types and helpers for the truth-table sweep controller.
//            Provides the FSM state encoding, the default gate input count
//            and a latency helper giving the cycle in which `done` is high,
//            counted from the edge that accepts `start`.
// Revision : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

    localparam int TT_N_IN_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_sweep_state_e;

    // Cycle (counted from the start-accept edge) in which `done` is high.
    function automatic int tt_sweep_latency(input int n_in, input int settle);
        return (2 ** n_in) * (settle + 1) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : tt_settle_timer
// Purpose  : Loadable down-counter that measures the settle interval of one
//            vector. Counts down to zero and holds there.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            load          - load `value` into the counter this edge
//            value [W]     - reload value
//            expired       - counter is zero
// Revision : 1.0 - initial release
// ============================================================================
module tt_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl
// Purpose  : Sweeps every input combination of one N_IN-input gate in
//            ascending order, waits SETTLE cycles per vector, samples the
//            gate output into a captured truth table and compares it with a
//            latched expected table.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start, abort       - begin sweep (IDLE only) / cancel sweep
//            expected_tt [TT_W] - reference table, latched on accepted start
//            gate_in [N_IN]     - vector driven to the gate (bit 0 -> _0)
//            gate_out           - gate response
//            busy, done         - sweeping / one-cycle completion pulse
//            captured_tt [TT_W] - sampled table
//            match              - captured == expected, valid from done
//            first_bad_idx      - lowest mismatching index (logging build)
//            bad_cnt [N_IN+1]   - mismatching index count (logging build)
// Config   : TT_SWEEP_MISMATCH_LOG_EN enables first_bad_idx / bad_cnt;
//            otherwise both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter  int N_IN   = TT_N_IN_DEFAULT,
    parameter  int SETTLE = 1,
    localparam int TT_W   = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] captured_tt,
    output logic            match,
    output logic [N_IN-1:0] first_bad_idx,
    output logic [N_IN:0]   bad_cnt
);

    localparam logic [N_IN:0] c_last_idx = (N_IN + 1)'(TT_W - 1);
    // The timer counts the SETTLE cycles as reload..0, so it is loaded with
    // SETTLE-1. With SETTLE=0 the SETTLE state is never entered.
    localparam logic [3:0]    c_reload   = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);

    tt_sweep_state_e r_state;
    logic [N_IN:0]   r_idx;
    logic [TT_W-1:0] r_exp;

    logic w_accept;
    logic w_load;
    logic w_expired;

    assign w_accept = (r_state == ST_IDLE) && start && !abort;
    assign w_load   = w_accept || ((r_state == ST_SAMPLE) && (r_idx != c_last_idx));
    assign gate_in  = r_idx[N_IN-1:0];

    tt_settle_timer #(
        .W (4)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .value   (c_reload),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_exp       <= '0;
            captured_tt <= '0;
            match       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_exp       <= expected_tt;
                        captured_tt <= '0;
                        match       <= 1'b0;
                        r_idx       <= '0;
                        busy        <= 1'b1;
                        r_state     <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_expired) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        captured_tt[r_idx[N_IN-1:0]] <= gate_out;
                        if (r_idx == c_last_idx) begin
                            busy    <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + (N_IN + 1)'(1);
                            r_state <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    // The last sample landed on the previous edge, so the
                    // compare sees the complete table here.
                    if (!abort) begin
                        done  <= 1'b1;
                        match <= (captured_tt == r_exp);
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TT_SWEEP_MISMATCH_LOG_EN
    logic [N_IN-1:0] r_first_bad;
    logic [N_IN:0]   r_bad_cnt;
    logic            w_bad;

    assign w_bad = (r_state == ST_SAMPLE) && !abort &&
                   (gate_out != r_exp[r_idx[N_IN-1:0]]);

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_first_bad <= '0;
            r_bad_cnt   <= '0;
        end else if (w_bad) begin
            r_bad_cnt <= r_bad_cnt + (N_IN + 1)'(1);
            if (r_bad_cnt == '0) begin
                r_first_bad <= r_idx[N_IN-1:0];
            end
        end
    end

    assign first_bad_idx = r_first_bad;
    assign bad_cnt       = r_bad_cnt;
`else
    assign first_bad_idx = '0;
    assign bad_cnt       = '0;
`endif

endmodule
`default_nettype wire
